fb_fetch: RTL and testbench

FB_FETCH -- requirements
Module: fb_fetch

---
 rtl/fb_pkg.sv | 14 +
 rtl/byte_fifo.sv | 45 ++++
 rtl/fb_fetch.sv | 117 +++++++++++
 tb/tb_fb_fetch.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants and FSM encoding for the frame-buffer fetch path
package fb_pkg;
  localparam int ADDR_W         = 19;
  localparam int FRAME_PIX_DEF  = 307200;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int LOW_WM_DEF     = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - byte FIFO with level output and synchronous flush
module byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [LW-1:0] level,
  output logic          empty
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (level != LW'(DEPTH));
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  // Flush beats any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fb_fetch.sv
// rtl/fb_fetch.sv - pixel prefetch and host-write arbiter in front of a shared SRAM controller
module fb_fetch
  import fb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 19'h00000,
  parameter int                FRAME_PIX  = FRAME_PIX_DEF,
  parameter int                FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int                LOW_WM     = LOW_WM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_rd,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  output logic              underflow,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  output logic              sram_trig,
  output logic              sram_rw,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  input  logic [7:0]        sram_rdata,
  input  logic              sram_done
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BASE_ADDR + FRAME_PIX - 1);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] rd_addr;
  logic              inflight;
  logic              discard;
  logic [LW-1:0]     level;
  logic [LW:0]       occ;
  logic              fifo_empty;
  logic              fifo_push;
  logic              sel_rd, sel_wr, start, done_xfer;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (frame_start),
    .push  (fifo_push),
    .din   (sram_rdata),
    .pop   (pix_rd),
    .dout  (pix_data),
    .level (level),
    .empty (fifo_empty)
  );

  assign pix_valid = !fifo_empty;
  assign occ       = {1'b0, level} + {{LW{1'b0}}, inflight};

  // No new transaction is chosen in a frame_start cycle so a stale address never goes out.
  always_comb begin
    sel_rd = 1'b0;
    sel_wr = 1'b0;
    if (!frame_start) begin
      if (occ <= (LW+1)'(LOW_WM))          sel_rd = 1'b1;
      else if (wr_req)                     sel_wr = 1'b1;
      else if (occ < (LW+1)'(FIFO_DEPTH))  sel_rd = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    sram_trig  = 1'b0;
    unique case (state)
      IDLE:    if (sram_done && (sel_rd || sel_wr)) state_next = ISSUE;
      ISSUE:   begin
        sram_trig  = 1'b1;
        state_next = WAIT_LO;
      end
      WAIT_LO: if (!sram_done) state_next = WAIT_HI;
      WAIT_HI: if (sram_done)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    start     = (state == IDLE) && (state_next == ISSUE);
    done_xfer = (state == WAIT_HI) && sram_done;
    wr_ack    = done_xfer && !sram_rw;
    fifo_push = done_xfer && sram_rw && !discard && !frame_start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sram_rw    <= 1'b1;
      sram_addr  <= '0;
      sram_wdata <= '0;
      rd_addr    <= BASE_ADDR;
      inflight   <= 1'b0;
      discard    <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state <= state_next;
      // Command fields are frozen here and held until the next start.
      if (start) begin
        sram_rw   <= sel_rd;
        sram_addr <= sel_rd ? rd_addr : wr_addr;
        if (!sel_rd) sram_wdata <= wr_data;
        inflight  <= sel_rd;
      end else if (done_xfer) begin
        inflight  <= 1'b0;
      end
      if (frame_start)
        rd_addr <= BASE_ADDR;
      else if (start && sel_rd)
        rd_addr <= (rd_addr == LAST_ADDR) ? BASE_ADDR : rd_addr + 1'b1;
      if (done_xfer)                           discard <= 1'b0;
      else if (frame_start && state != IDLE)   discard <= 1'b1;
      if (frame_start)                 underflow <= 1'b0;
      else if (pix_rd && fifo_empty)   underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fb_fetch.sv
// tb/tb_fb_fetch.sv - scoreboard bench for fb_fetch with a behavioural SRAM controller and pixel model
module tb_fb_fetch;
  localparam int FPIX  = 40;
  localparam int DEPTH = 16;
  localparam int LWM   = 4;

  logic        clk = 1'b0;
  logic        rst, frame_start, pix_rd, wr_req;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  pix_data;
  logic        pix_valid, underflow, wr_ack, sram_trig, sram_rw;
  logic [18:0] sram_addr;
  logic [7:0]  sram_wdata;
  logic [7:0]  rdata_r = 8'h00;
  logic        done_r  = 1'b1;

  always #5 clk = ~clk;

  fb_fetch #(.BASE_ADDR(19'h00000), .FRAME_PIX(FPIX), .FIFO_DEPTH(DEPTH), .LOW_WM(LWM)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_rd(pix_rd),
    .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .sram_trig(sram_trig), .sram_rw(sram_rw), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(rdata_r), .sram_done(done_r)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {logic [18:0] a; logic [7:0] d;} wr_t;

  logic [7:0]  mem [logic [18:0]];
  logic [7:0]  pix_q [$];
  wr_t         wr_q [$];
  logic        model_uf;
  logic [18:0] exp_rd;
  int          n_rd_trig = 0;
  int          n_ack = 0;
  int          n_wr = 0;
  logic        wr_issued = 1'b0;

  logic        busy = 1'b0;
  int          cnt = 0;
  logic        c_rw, c_disc, cmpl, pushv;
  logic [18:0] c_addr;
  logic [7:0]  c_wdata, pv;

  function automatic logic [7:0] mem_rd(input logic [18:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  // Controller model (done low two cycles after trig) plus the pixel FIFO reference.
  always @(posedge clk) begin
    if (rst) begin
      done_r <= 1'b1;
      busy = 1'b0;
      cnt = 0;
      pix_q.delete();
      model_uf = 1'b0;
      exp_rd = 19'h0;
    end else begin
      cmpl  = busy && done_r && (cnt == 0);
      pushv = 1'b0;
      pv    = rdata_r;
      if (cmpl) begin
        busy = 1'b0;
        if (c_rw) pushv = !c_disc && !frame_start;
        else      mem[c_addr] = c_wdata;
      end else if (sram_trig) begin
        busy = 1'b1;
        cnt = 2;
        done_r <= 1'b0;
        c_rw = sram_rw;
        c_addr = sram_addr;
        c_wdata = sram_wdata;
        c_disc = frame_start;
      end else if (busy && cnt > 0) begin
        cnt--;
        if (frame_start) c_disc = 1'b1;
        if (cnt == 0) begin
          done_r  <= 1'b1;
          rdata_r <= mem_rd(c_addr);
        end
      end
      if (frame_start) begin
        pix_q.delete();
        model_uf = 1'b0;
        exp_rd = 19'h0;
      end else begin
        if (pix_rd) begin
          if (pix_q.size() == 0) model_uf = 1'b1;
          else void'(pix_q.pop_front());
        end
        if (pushv) pix_q.push_back(pv);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("pix_valid", pix_valid, pix_q.size() != 0);
      if (pix_q.size() != 0) check("pix_data", pix_data, pix_q[0]);
      check("underflow", underflow, model_uf);
      if (busy) begin
        check("hold_rw", sram_rw, c_rw);
        check("hold_addr", sram_addr, c_addr);
        check("hold_wdata", sram_wdata, c_wdata);
      end
      if (sram_trig) begin
        if (sram_rw) begin
          check("rd_addr", sram_addr, exp_rd);
          check("rd_room", pix_q.size() < DEPTH, 1);
          exp_rd = (exp_rd == 19'(FPIX - 1)) ? 19'h0 : exp_rd + 19'h1;
          n_rd_trig++;
        end else if (wr_q.size() == 0) begin
          check("wr_unexpected", 0, 1);
        end else begin
          check("wr_addr", sram_addr, wr_q[0].a);
          check("wr_data", sram_wdata, wr_q[0].d);
          wr_issued = 1'b1;
        end
      end
      if (wr_ack) begin
        check("ack_req", wr_req, 1);
        check("ack_issued", wr_issued, 1);
        wr_issued = 1'b0;
        if (wr_q.size() != 0) void'(wr_q.pop_front());
        n_ack++;
      end
    end
  end

  task automatic do_write(input logic [18:0] wa, input logic [7:0] wd, input logic fs);
    logic seen;
    seen = 1'b0;
    wr_addr = wa;
    wr_data = wd;
    wr_q.push_back('{a: wa, d: wd});
    n_wr++;
    wr_req = 1'b1;
    if (fs) frame_start = 1'b1;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      if (fs) frame_start = 1'b0;
      // Scramble the host bus once the command is out: the DUT must have captured it already.
      if (sram_trig && !sram_rw) begin
        wr_addr = 19'($urandom);
        wr_data = 8'($urandom);
      end
      if (wr_ack) seen = 1'b1;
    end
    check("wr_ack_seen", seen, 1);
    if (seen) begin
      @(posedge clk); #1;
      check("wr_ack_pulse", wr_ack, 0);
    end
    wr_req = 1'b0;
  endtask

  logic rnd_done = 1'b0;
  int   base;
  logic found;

  initial begin
    rst = 1'b1; frame_start = 1'b0; pix_rd = 1'b0; wr_req = 1'b0;
    wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_trig", sram_trig, 0);
    check("rst_rw", sram_rw, 1);
    check("rst_addr", sram_addr, 0);
    check("rst_wdata", sram_wdata, 0);
    check("rst_ack", wr_ack, 0);
    check("rst_uf", underflow, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_data", pix_data, 0);
    @(posedge clk); #1 rst = 1'b0;

    repeat (120) @(posedge clk); #1;
    check("fill_reads", n_rd_trig, DEPTH);
    check("fill_valid", pix_valid, 1);

    do_write(19'h40001, 8'hA5, 1'b0);
    check("full_no_read", n_rd_trig, DEPTH);

    // Flush with a write pending: reads win until occupancy passes the low watermark.
    repeat (10) @(posedge clk); #1;
    base = n_rd_trig;
    do_write(19'h00003, 8'h3C, 1'b1);
    check("reads_before_write", n_rd_trig - base, LWM + 1);

    repeat (80) @(posedge clk); #1;
    pix_rd = 1'b1;
    @(posedge clk); #1 pix_rd = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (sram_trig && sram_rw) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("refill_trig", found, 1);
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    check("flush_empty", pix_valid, 0);
    pix_rd = 1'b1;
    @(posedge clk); #1 pix_rd = 1'b0;
    check("uf_set", underflow, 1);
    repeat (30) @(posedge clk); #1;
    check("uf_held", underflow, 1);
    frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    check("uf_clear", underflow, 0);

    fork
      begin
        for (int i = 0; i < 3000; i++) begin
          pix_rd      = ($urandom_range(0, 5) == 0);
          frame_start = ($urandom_range(0, 299) == 0);
          @(posedge clk); #1;
        end
        pix_rd = 1'b0;
        frame_start = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          repeat ($urandom_range(0, 20)) @(posedge clk);
          #1;
          if (!rnd_done)
            do_write($urandom_range(0, 1) ? 19'($urandom_range(0, FPIX - 1)) : 19'($urandom),
                     8'($urandom), 1'b0);
        end
      end
    join

    repeat (50) @(posedge clk); #1;
    check("ack_count", n_ack, n_wr);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
